parser_head_gen: RTL and testbench
==================================

# parser_head_gen

Transmit-side front end of the pipelined packet parser. It slices an incoming 64-bit packet byte stream into tagged HEAD_WIDTH head slices plus one tagged META_WIDTH meta slice per packet, in the exact format layer 1 of the parser consumes on `i_head`/`i_meta`. Packet bytes beyond the configured head depth are consumed and discarded. The block sits directly upstream of the parser top, between the packet ingress and the parser pipeline.

## Interface
Parameters:
- HEAD_WIDTH, default parser_pkg value (512): head slice data width in bits.
- META_WIDTH, default parser_pkg value (512): meta slice data width in bits.
- TAG_WIDTH, default parser_pkg value: tag field width. Tag bit positions TAG_VALID_BIT, TAG_START_BIT, TAG_TAIL_BIT, TAG_SHIFT_BIT and the TAG_OFFSET field come from parser_pkg.
- IN_WIDTH, default 64: input beat width in bits. HEAD_WIDTH/IN_WIDTH = 8 beats per slice.
- HEAD_SLICE_NUM, default 2: maximum head slices emitted per packet.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: reset. One clock; reset is asynchronous and active-low.
- i_pkt_valid, in, 1: input beat valid.
- o_pkt_ready, out, 1: input ready.
- i_pkt_data, in, IN_WIDTH: beat data. The first byte in time is in [IN_WIDTH-1 -: 8].
- i_pkt_last, in, 1: last beat of packet.
- i_pkt_bytes, in, 3: valid bytes minus 1 on the last beat. Ignored on non-last beats, where all 8 bytes are valid.
- i_meta_in, in, META_WIDTH: per-packet metadata. Sampled on the first beat of each packet.
- o_head, out, HEAD_WIDTH+TAG_WIDTH: head slice. The tag is in the upper TAG_WIDTH bits. Packet byte k of the slice is at [HEAD_WIDTH-1-8k -: 8].
- o_meta, out, META_WIDTH+TAG_WIDTH: meta slice, with the same tag layout as o_head.
- o_pkt_cnt, out, 32: packets fully accepted.
- o_trunc_cnt, out, 32: packets longer than HEAD_SLICE_NUM slices.

## Operation
- A beat is accepted when i_pkt_valid & o_pkt_ready. o_pkt_ready = 1 whenever out of reset; the block never backpressures.
- States:
  - IDLE: no packet in progress. An accepted beat starts a packet: sample i_meta_in, clear slice_cnt, go to FILL.
  - FILL: write the beat into shift buffer position beat_cnt (0..7), then increment beat_cnt.
  - DROP: accept and discard beats until i_pkt_last, then return to IDLE.
- Slice emit: triggered by an accepted beat with beat_cnt==7 or i_pkt_last while in FILL. The emitted slice has:
  - valid=1 and shift=1;
  - start=1 iff slice_cnt==0;
  - tail=1 iff the beat is last or slice_cnt==HEAD_SLICE_NUM-1;
  - offset = index of the last valid byte in the slice, computed as beat_cnt*8 + (last ? i_pkt_bytes : 7), 6-bit range 0..63;
  - bytes after offset zeroed.
  After emit, clear beat_cnt and the buffer, then slice_cnt++.
- State after an emit:
  - beat is last: go to IDLE and increment o_pkt_cnt;
  - not last and tail set: go to DROP and increment o_trunc_cnt; o_pkt_cnt increments on the last beat in DROP;
  - otherwise stay in FILL.
- Meta emit: on the same cycle as the start head slice, o_meta carries the sampled meta with valid=start=tail=1, shift=0, offset=META_WIDTH/8-1. In every other cycle the o_meta tag is 0.
- Between emits, o_head and o_meta tags are all-zero. Data fields hold their last value and carry no meaning.
- Counters are 32-bit and wrap mod 2^32.

## Timing
- Reset: all tags 0, data 0, counters 0, state IDLE, o_pkt_ready=0 during reset.
- Latency: o_head/o_meta are registered. Each slice appears exactly one cycle after the accepting edge of its completing beat and is a one-cycle pulse.
- Back-to-back packets: the first beat of packet N+1 may be accepted in the cycle after the last beat of packet N. Slices are emitted in consecutive cycles with no gap.
- A one-beat packet produces one head slice with start=tail=valid=1, plus meta in the same cycle.
- Reset asserted mid-packet: the partial slice is discarded and no tail is emitted. After reset, the next beat starts a new packet.
- i_pkt_valid=0 mid-slice stalls filling with no emit; no timeout.

## Test plan
- 14-byte packet (beat 2 last, bytes=5): one slice one cycle later with start=tail=valid=1, offset=13, bytes 14..63 zero, meta valid in the same cycle; o_pkt_cnt=1.
- 64-byte packet (8 beats, bytes=7): single slice with offset=63, start=tail=1.
- 100-byte packet: slice 0 has start=1, tail=0, offset=63; slice 1 has start=0, tail=1, offset=35; meta only with slice 0.
- 200-byte packet, HEAD_SLICE_NUM=2: two slices, slice 1 tail=1 offset=63, the remaining 9 beats dropped with no output; o_trunc_cnt=1, o_pkt_cnt=1.
- Back-to-back 1-beat packets for 4 cycles: 4 consecutive start+tail slices, each with the correct per-packet meta.
- Reset pulse after 3 beats of a packet, then a new 8-byte packet: no slice from the aborted packet, counters 0 during reset, new slice with start=tail=1 and offset=7.

Source files
------------

// File: rtl/parser_head_gen_if.sv
// parser_head_gen_if: ingress packet beat stream into the head generator.
// Beats carry up to IN_WIDTH bits with last/bytes framing plus per-packet meta.
interface parser_head_gen_if #(
  parameter int IN_WIDTH   = 64,
  parameter int META_WIDTH = 512
);
  logic                  i_pkt_valid;
  logic                  o_pkt_ready;
  logic [IN_WIDTH-1:0]   i_pkt_data;
  logic                  i_pkt_last;
  logic [2:0]            i_pkt_bytes;
  logic [META_WIDTH-1:0] i_meta_in;

  modport master (
    output i_pkt_valid,
    output i_pkt_data,
    output i_pkt_last,
    output i_pkt_bytes,
    output i_meta_in,
    input  o_pkt_ready
  );

  modport slave (
    input  i_pkt_valid,
    input  i_pkt_data,
    input  i_pkt_last,
    input  i_pkt_bytes,
    input  i_meta_in,
    output o_pkt_ready
  );
endinterface

// File: rtl/parser_head_gen.sv
// parser_head_gen: slices a packet byte stream into tagged head/meta slices.
// Bytes beyond HEAD_SLICE_NUM slices are consumed and discarded.
package parser_pkg;
  localparam int HEAD_W         = 512;
  localparam int META_W         = 512;
  localparam int TAG_W          = 12;
  localparam int TAG_VALID_BIT  = 11;
  localparam int TAG_START_BIT  = 10;
  localparam int TAG_TAIL_BIT   = 9;
  localparam int TAG_SHIFT_BIT  = 8;
  localparam int TAG_OFFSET_LSB = 0;
  localparam int TAG_OFFSET_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DROP
  } hg_state_e;
endpackage

module parser_head_gen
  import parser_pkg::*;
#(
  parameter int HEAD_WIDTH     = HEAD_W,
  parameter int META_WIDTH     = META_W,
  parameter int TAG_WIDTH      = TAG_W,
  parameter int IN_WIDTH       = 64,
  parameter int HEAD_SLICE_NUM = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  parser_head_gen_if.slave              pkt,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta,
  output logic [31:0]                   o_pkt_cnt,
  output logic [31:0]                   o_trunc_cnt
);

  localparam int BEATS = HEAD_WIDTH / IN_WIDTH;
  localparam int BB    = IN_WIDTH / 8;
  localparam int BC_W  = $clog2(BEATS);
  localparam int SC_W  = $clog2(HEAD_SLICE_NUM + 1);
  localparam int OFF_W = $clog2(HEAD_WIDTH / 8);
  localparam int PAD   = HEAD_WIDTH - IN_WIDTH;

  hg_state_e st_q, st_d;

  logic [BC_W-1:0]       beat_q;
  logic [SC_W-1:0]       slc_q;
  logic [HEAD_WIDTH-1:0] buf_q;
  logic [META_WIDTH-1:0] meta_q;
  logic                  rdy_q;
  logic [31:0]           pkt_q;
  logic [31:0]           trunc_q;

  logic [TAG_WIDTH-1:0]  head_tag_q;
  logic [HEAD_WIDTH-1:0] head_dat_q;
  logic [TAG_WIDTH-1:0]  meta_tag_q;
  logic [META_WIDTH-1:0] meta_dat_q;

  logic                  acc;
  logic                  last;
  logic                  fill_st;
  logic                  emit;
  logic                  start;
  logic                  tail;
  logic                  pkt_inc;
  logic                  trunc_inc;
  logic [SC_W-1:0]       eff_slc;
  logic [2:0]            nbytes;
  logic [2:0]            sh;
  logic [IN_WIDTH-1:0]   beat_msk;
  logic [OFF_W-1:0]      offset;
  logic [HEAD_WIDTH-1:0] slice_d;
  logic [META_WIDTH-1:0] meta_src;
  logic [TAG_WIDTH-1:0]  head_tag_d;
  logic [TAG_WIDTH-1:0]  meta_tag_d;

  assign pkt.o_pkt_ready = rdy_q;
  assign acc  = pkt.i_pkt_valid & rdy_q;
  assign last = pkt.i_pkt_last;

  // Datapath: mask the beat, drop it into its buffer lane, form offset.
  always_comb begin
    nbytes   = last ? pkt.i_pkt_bytes : 3'(BB - 1);
    sh       = 3'(BB - 1) - nbytes;
    beat_msk = {IN_WIDTH{1'b1}} << {sh, 3'b000};
    slice_d  = buf_q
             | ({pkt.i_pkt_data & beat_msk, {PAD{1'b0}}}
                >> (IN_WIDTH * int'(beat_q)));
    offset   = OFF_W'(beat_q) * OFF_W'(BB) + OFF_W'(nbytes);
    meta_src = (st_q == ST_IDLE) ? pkt.i_meta_in : meta_q;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) st_q <= ST_IDLE;
    else          st_q <= st_d;
  end

  // Next state: fill until last beat or slice budget runs out.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE, ST_FILL: begin
        if (acc) begin
          if (emit && last)      st_d = ST_IDLE;
          else if (emit && tail) st_d = ST_DROP;
          else                   st_d = ST_FILL;
        end
      end
      ST_DROP: begin
        if (acc && last) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // FSM outputs: emit strobe, slice framing, counter strobes, tags.
  always_comb begin
    fill_st   = (st_q != ST_DROP);
    eff_slc   = (st_q == ST_IDLE) ? '0 : slc_q;
    emit      = acc & fill_st
              & ((beat_q == BC_W'(BEATS - 1)) | last);
    start     = (eff_slc == '0);
    tail      = last | (eff_slc == SC_W'(HEAD_SLICE_NUM - 1));
    pkt_inc   = acc & last;
    trunc_inc = emit & ~last & tail;

    head_tag_d = '0;
    head_tag_d[TAG_VALID_BIT] = 1'b1;
    head_tag_d[TAG_SHIFT_BIT] = 1'b1;
    head_tag_d[TAG_START_BIT] = start;
    head_tag_d[TAG_TAIL_BIT]  = tail;
    head_tag_d[TAG_OFFSET_LSB +: TAG_OFFSET_W] = TAG_OFFSET_W'(offset);

    meta_tag_d = '0;
    meta_tag_d[TAG_VALID_BIT] = 1'b1;
    meta_tag_d[TAG_START_BIT] = 1'b1;
    meta_tag_d[TAG_TAIL_BIT]  = 1'b1;
    meta_tag_d[TAG_OFFSET_LSB +: TAG_OFFSET_W] =
      TAG_OFFSET_W'(META_WIDTH / 8 - 1);
  end

  // Beat and slice position within the packet.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_q <= '0;
      slc_q  <= '0;
    end else if (acc && fill_st) begin
      beat_q <= emit ? '0 : beat_q + 1'b1;
      slc_q  <= emit ? eff_slc + 1'b1 : eff_slc;
    end
  end

  // Slice accumulation buffer, cleared on each emit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              buf_q <= '0;
    else if (emit)             buf_q <= '0;
    else if (acc && fill_st)   buf_q <= slice_d;
  end

  // Meta captured from the first beat of each packet.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      meta_q <= '0;
    else if (acc && st_q == ST_IDLE)   meta_q <= pkt.i_meta_in;
  end

  // Registered head/meta slices; tags pulse for one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_tag_q <= '0;
      head_dat_q <= '0;
      meta_tag_q <= '0;
      meta_dat_q <= '0;
    end else begin
      head_tag_q <= '0;
      meta_tag_q <= '0;
      if (emit) begin
        head_tag_q <= head_tag_d;
        head_dat_q <= slice_d;
        if (start) begin
          meta_tag_q <= meta_tag_d;
          meta_dat_q <= meta_src;
        end
      end
    end
  end

  // Ready rises the first edge after reset and stays up.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  // Packet and truncation counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_q   <= '0;
      trunc_q <= '0;
    end else begin
      if (pkt_inc)   pkt_q   <= pkt_q + 32'd1;
      if (trunc_inc) trunc_q <= trunc_q + 32'd1;
    end
  end

  assign o_head      = {head_tag_q, head_dat_q};
  assign o_meta      = {meta_tag_q, meta_dat_q};
  assign o_pkt_cnt   = pkt_q;
  assign o_trunc_cnt = trunc_q;

endmodule

// File: tb/tb_parser_head_gen.sv
// tb_parser_head_gen: directed packet table plus reset and
// back-to-back sequences for the head slice generator.
module tb_parser_head_gen;
  import parser_pkg::*;

  localparam int HW  = 512;
  localparam int MW  = 512;
  localparam int TW  = TAG_W;
  localparam int IW  = 64;
  localparam int HSN = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [HW+TW-1:0] o_head;
  logic [MW+TW-1:0] o_meta;
  logic [31:0]   o_pkt_cnt;
  logic [31:0]   o_trunc_cnt;

  parser_head_gen_if #(.IN_WIDTH(IW), .META_WIDTH(MW)) pif ();

  parser_head_gen #(
    .HEAD_WIDTH(HW), .META_WIDTH(MW), .TAG_WIDTH(TW),
    .IN_WIDTH(IW), .HEAD_SLICE_NUM(HSN)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .pkt(pif),
    .o_head(o_head),
    .o_meta(o_meta),
    .o_pkt_cnt(o_pkt_cnt),
    .o_trunc_cnt(o_trunc_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         len;
    logic [7:0] seed;
    int         gap;
    int         nslc;
    int         off_last;
    int         trunc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic          pend_v = 1'b0;
  logic [TW-1:0] pend_tag;
  logic [HW-1:0] pend_dat;
  logic [MW-1:0] pend_meta;
  int            seen;
  int            last_off;
  int            exp_pkt;
  int            exp_trunc;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_tag(input logic st, input logic tl,
                                           input int off, input logic sh);
    logic [TW-1:0] t;
    t = '0;
    t[TAG_VALID_BIT] = 1'b1;
    t[TAG_SHIFT_BIT] = sh;
    t[TAG_START_BIT] = st;
    t[TAG_TAIL_BIT]  = tl;
    t[TAG_OFFSET_LSB +: TAG_OFFSET_W] = TAG_OFFSET_W'(off);
    return t;
  endfunction

  task automatic check_pending();
    logic [TW-1:0] mt;
    logic          mexp;
    chk("head_tag", 512'(o_head[HW+TW-1 -: TW]), pend_v ? 512'(pend_tag) : '0);
    if (pend_v) chk("head_data", o_head[HW-1:0], pend_dat);
    mexp = pend_v && pend_tag[TAG_START_BIT];
    mt = mexp ? mk_tag(1'b1, 1'b1, MW / 8 - 1, 1'b0) : '0;
    chk("meta_tag", 512'(o_meta[MW+TW-1 -: TW]), 512'(mt));
    if (mexp) chk("meta_data", o_meta[MW-1:0], pend_meta);
    if (o_head[HW+TAG_VALID_BIT]) begin
      seen++;
      last_off = int'(o_head[HW+TAG_OFFSET_LSB +: TAG_OFFSET_W]);
    end
    pend_v = 1'b0;
  endtask

  task automatic drive(input logic [IW-1:0] d, input logic lst,
                       input logic [2:0] nb, input logic [MW-1:0] m);
    @(negedge i_clk);
    check_pending();
    pif.i_pkt_valid = 1'b1;
    pif.i_pkt_data  = d;
    pif.i_pkt_last  = lst;
    pif.i_pkt_bytes = nb;
    pif.i_meta_in   = m;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      check_pending();
      pif.i_pkt_valid = 1'b0;
      pif.i_pkt_last  = 1'b0;
    end
  endtask

  task automatic send_pkt(input int len, input logic [7:0] seed,
                          input logic [MW-1:0] m, input int gap);
    int            nbeats;
    int            s;
    int            off;
    logic          lst;
    logic [IW-1:0] d;
    logic [HW-1:0] e;
    nbeats = (len + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      for (int j = 0; j < 8; j++)
        d[63-8*j -: 8] = (8*b + j < len) ? seed + 8'(8*b + j) : 8'hA5;
      lst = (b == nbeats - 1);
      if (gap > 0 && b > 0) idle(gap);
      drive(d, lst, lst ? 3'((len - 1) % 8) : 3'd2, (b == 0) ? m : ~m);
      s = b / 8;
      if (s < HSN && (b % 8 == 7 || lst)) begin
        off = lst ? len - 1 - 64*s : 63;
        for (int j = 0; j < 64; j++)
          e[511-8*j -: 8] = (j <= off) ? seed + 8'(64*s + j) : 8'h00;
        pend_v    = 1'b1;
        pend_tag  = mk_tag(s == 0, lst || s == HSN - 1, off, 1'b1);
        pend_dat  = e;
        pend_meta = m;
      end
    end
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{len: 14,  seed: 8'h10, gap: 0, nslc: 1, off_last: 13, trunc: 0};
    vt[1] = '{len: 64,  seed: 8'h20, gap: 0, nslc: 1, off_last: 63, trunc: 0};
    vt[2] = '{len: 100, seed: 8'h30, gap: 0, nslc: 2, off_last: 35, trunc: 0};
    vt[3] = '{len: 200, seed: 8'h40, gap: 0, nslc: 2, off_last: 63, trunc: 1};
    vt[4] = '{len: 8,   seed: 8'h50, gap: 0, nslc: 1, off_last: 7,  trunc: 0};
    vt[5] = '{len: 1,   seed: 8'h60, gap: 0, nslc: 1, off_last: 0,  trunc: 0};
    vt[6] = '{len: 65,  seed: 8'h70, gap: 0, nslc: 2, off_last: 0,  trunc: 0};
    vt[7] = '{len: 128, seed: 8'h80, gap: 0, nslc: 2, off_last: 63, trunc: 0};
    vt[8] = '{len: 129, seed: 8'h90, gap: 0, nslc: 2, off_last: 63, trunc: 1};
    vt[9] = '{len: 20,  seed: 8'hA0, gap: 3, nslc: 1, off_last: 19, trunc: 0};

    pif.i_pkt_valid = 1'b0;
    pif.i_pkt_data  = '0;
    pif.i_pkt_last  = 1'b0;
    pif.i_pkt_bytes = '0;
    pif.i_meta_in   = '0;
    exp_pkt   = 0;
    exp_trunc = 0;
    seen      = 0;
    last_off  = -1;

    repeat (2) @(negedge i_clk);
    chk("rst_ready", 512'(pif.o_pkt_ready), 512'(0));
    chk("rst_head", o_head[HW-1:0], '0);
    chk("rst_head_tag", 512'(o_head[HW+TW-1 -: TW]), '0);
    chk("rst_meta_tag", 512'(o_meta[MW+TW-1 -: TW]), '0);
    chk("rst_pkt_cnt", 512'(o_pkt_cnt), '0);
    chk("rst_trunc_cnt", 512'(o_trunc_cnt), '0);
    i_rst_n = 1'b1;
    idle(1);
    chk("ready_up", 512'(pif.o_pkt_ready), 512'(1));

    for (int i = 0; i < 10; i++) begin
      seen = 0;
      last_off = -1;
      send_pkt(vt[i].len, vt[i].seed, {16{32'hC0DE0000 + 32'(i)}}, vt[i].gap);
      idle(1);
      exp_pkt   += 1;
      exp_trunc += vt[i].trunc;
      chk($sformatf("v%0d_nslc", i), 512'(seen), 512'(vt[i].nslc));
      chk($sformatf("v%0d_off", i), 512'(last_off), 512'(vt[i].off_last));
      chk($sformatf("v%0d_pkt_cnt", i), 512'(o_pkt_cnt), 512'(exp_pkt));
      chk($sformatf("v%0d_trunc_cnt", i), 512'(o_trunc_cnt), 512'(exp_trunc));
    end

    seen = 0;
    send_pkt(3, 8'h01, {16{32'hB2B00001}}, 0);
    send_pkt(8, 8'h11, {16{32'hB2B00002}}, 0);
    send_pkt(1, 8'h21, {16{32'hB2B00003}}, 0);
    send_pkt(5, 8'h31, {16{32'hB2B00004}}, 0);
    idle(1);
    exp_pkt += 4;
    chk("b2b_nslc", 512'(seen), 512'(4));
    chk("b2b_off", 512'(last_off), 512'(4));
    chk("b2b_pkt_cnt", 512'(o_pkt_cnt), 512'(exp_pkt));

    seen = 0;
    for (int b = 0; b < 3; b++)
      drive({8{8'h5A}}, 1'b0, 3'd0, {16{32'hDEAD0000}});
    @(negedge i_clk);
    check_pending();
    pif.i_pkt_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 512'(pif.o_pkt_ready), 512'(0));
    chk("mid_rst_pkt_cnt", 512'(o_pkt_cnt), '0);
    chk("mid_rst_trunc_cnt", 512'(o_trunc_cnt), '0);
    chk("mid_rst_head_tag", 512'(o_head[HW+TW-1 -: TW]), '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_pkt   = 0;
    exp_trunc = 0;
    send_pkt(8, 8'hC0, {16{32'h0BADF00D}}, 0);
    idle(2);
    exp_pkt += 1;
    chk("post_rst_nslc", 512'(seen), 512'(1));
    chk("post_rst_off", 512'(last_off), 512'(7));
    chk("post_rst_pkt_cnt", 512'(o_pkt_cnt), 512'(exp_pkt));
    chk("post_rst_trunc_cnt", 512'(o_trunc_cnt), 512'(exp_trunc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
